ifetch_rsp: RTL and testbench

Responder end of the IFU fetch interface. Accepts fetch requests (valid/address/ready), issues them to the instruction SRAM, and buffers the returned 128-bit lines with their instruction-select tags until the IDU takes them. Applies backpressure to the IFU with a credit scheme so that no SRAM return is ever dropped. On a jump flush, discards all stale data.

---
 rtl/ifetch_rsp_pkg.sv | 9 +
 rtl/ifetch_rsp_if.sv | 28 ++
 rtl/ifetch_rsp_fifo.sv | 42 ++++
 rtl/ifetch_rsp.sv | 51 +++++
 tb/tb_ifetch_rsp.sv | 131 +++++++++++++
 5 files changed

// File: rtl/ifetch_rsp_pkg.sv
// ifetch_rsp_pkg: fetch constants shared with the IFU and IDU, plus the tag-stage record
package ifetch_rsp_pkg;
  localparam int ANOM_PC_WIDTH = 30;
  localparam int ANOM_FETCH_DATA_WIDTH = 128;
  typedef struct packed {
    logic v;
    logic [1:0] sel;
  } tag_t;
endpackage

// File: rtl/ifetch_rsp_if.sv
// ifetch_rsp_if: IFU request, SRAM port and IDU response signals of the fetch responder
interface ifetch_rsp_if
  import ifetch_rsp_pkg::*;
#(
  parameter int PC_WIDTH = ANOM_PC_WIDTH,
  parameter int DATA_WIDTH = ANOM_FETCH_DATA_WIDTH
);
  logic fetchV;
  logic [PC_WIDTH-3:0] fetchA;
  logic fetchR;
  logic [1:0] instrSel;
  logic flush;
  logic memReqV;
  logic [PC_WIDTH-3:0] memAddr;
  logic [DATA_WIDTH-1:0] memRData;
  logic rspV;
  logic [DATA_WIDTH-1:0] rspData;
  logic [1:0] rspSel;
  logic rspR;
  modport master (
    output fetchV, fetchA, instrSel, flush, memRData, rspR,
    input fetchR, memReqV, memAddr, rspV, rspData, rspSel
  );
  modport slave (
    input fetchV, fetchA, instrSel, flush, memRData, rspR,
    output fetchR, memReqV, memAddr, rspV, rspData, rspSel
  );
endinterface

// File: rtl/ifetch_rsp_fifo.sv
// ifetch_rsp_fifo: synchronous FIFO with flush; caller never pushes into a full queue without popping
module ifetch_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic i_Clk,
  input  logic i_RstN,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [WIDTH-1:0] wData,
  output logic [WIDTH-1:0] rData,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0] wrPtr, rdPtr;
  logic doPop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign doPop = pop & ~empty;
  assign rData = empty ? '0 : mem[rdPtr];
  always_ff @(posedge i_Clk or negedge i_RstN)
    if (!i_RstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(push);
      rdPtr <= rdPtr + AW'(doPop);
      count <= count + CW'(push) - CW'(doPop);
    end
  always_ff @(posedge i_Clk)
    if (push & ~flush) mem[wrPtr] <= wData;
endmodule

// File: rtl/ifetch_rsp.sv
// ifetch_rsp: issues IFU fetches to the SRAM and queues returned lines for the IDU under credit flow control
module ifetch_rsp
  import ifetch_rsp_pkg::*;
#(
  parameter int PC_WIDTH = ANOM_PC_WIDTH,
  parameter int DATA_WIDTH = ANOM_FETCH_DATA_WIDTH,
  parameter int MEM_LATENCY = 2,
  parameter int QDEPTH = 4
) (
  input logic i_Clk,
  input logic i_RstN,
  ifetch_rsp_if.slave bus
);
  localparam int QW = $clog2(QDEPTH) + 1;
  tag_t tags [MEM_LATENCY];
  logic accept, pop, push, qFull, qEmpty;
  logic [QW-1:0] qCount, cnt;
  logic [DATA_WIDTH+1:0] qHead;
  assign bus.fetchR = (cnt < QW'(QDEPTH)) & ~bus.flush;
  assign accept = bus.fetchV & bus.fetchR;
  assign bus.memReqV = accept;
  assign bus.memAddr = bus.fetchA;
  assign pop = bus.rspV & bus.rspR;
  assign push = tags[MEM_LATENCY-1].v & (~qFull | pop);
  assign bus.rspV = ~qEmpty;
  assign {bus.rspData, bus.rspSel} = qHead;
  // every accepted request holds a credit until its line leaves the queue
  always_comb begin
    cnt = qCount;
    for (int i = 0; i < MEM_LATENCY; i++) cnt = cnt + QW'(tags[i].v);
  end
  always_ff @(posedge i_Clk or negedge i_RstN)
    if (!i_RstN) begin
      for (int i = 0; i < MEM_LATENCY; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{v: accept, sel: bus.instrSel};
      for (int i = 1; i < MEM_LATENCY; i++) tags[i] <= '{v: tags[i-1].v & ~bus.flush, sel: tags[i-1].sel};
    end
  ifetch_rsp_fifo #(.WIDTH(DATA_WIDTH + 2), .DEPTH(QDEPTH)) u_fifo (
    .i_Clk(i_Clk),
    .i_RstN(i_RstN),
    .push(push),
    .pop(pop),
    .flush(bus.flush),
    .wData({bus.memRData, tags[MEM_LATENCY-1].sel}),
    .rData(qHead),
    .full(qFull),
    .empty(qEmpty),
    .count(qCount)
  );
endmodule

// File: tb/tb_ifetch_rsp.sv
// tb_ifetch_rsp: directed vector bench for the fetch responder with a fixed-latency SRAM model
module tb_ifetch_rsp;
  import ifetch_rsp_pkg::*;
  localparam int PW = ANOM_PC_WIDTH;
  localparam int AW = PW - 2;
  localparam int DW = ANOM_FETCH_DATA_WIDTH;
  localparam int LAT = 2;
  typedef logic [AW-1:0] addr_t;
  typedef struct {
    logic fV; addr_t a; logic [1:0] sel; logic fl; logic rR;
    logic eFR; logic eReq; logic eRspV; logic [1:0] eSel; addr_t eA;
  } vec_t;
  logic clk = 0, rstN = 0;
  int checks = 0, errors = 0;
  vec_t vecs[$];
  logic [LAT-1:0] sv = '0;
  addr_t sa [LAT];
  always #5 clk = ~clk;
  ifetch_rsp_if #(.PC_WIDTH(PW), .DATA_WIDTH(DW)) bus ();
  ifetch_rsp #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .QDEPTH(4)) dut (
    .i_Clk(clk),
    .i_RstN(rstN),
    .bus(bus)
  );
  function automatic logic [DW-1:0] lineOf(input addr_t a);
    logic [31:0] w;
    w = 32'(a);
    return {32'hDEAD0000 ^ w, w, ~w, 32'h0000BEEF ^ w};
  endfunction
  // SRAM: data for an address appears exactly LAT cycles after its read enable, garbage otherwise
  always @(posedge clk) begin
    sv <= {sv[LAT-2:0], bus.memReqV};
    sa[0] <= bus.memAddr;
    for (int i = 1; i < LAT; i++) sa[i] <= sa[i-1];
  end
  assign bus.memRData = sv[LAT-1] ? lineOf(sa[LAT-1]) : {4{32'hBAD0BAD0}};
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic fV, input addr_t a, input logic [1:0] sel, input logic fl, input logic rR);
    bus.fetchV = fV;
    bus.fetchA = a;
    bus.instrSel = sel;
    bus.flush = fl;
    bus.rspR = rR;
  endtask
  task automatic step(input string nm, input logic fV, input addr_t a, input logic [1:0] sel,
                      input logic fl, input logic rR, input logic eFR, input logic eReq,
                      input logic eRspV, input logic [1:0] eSel, input addr_t eA);
    @(negedge clk);
    drive(fV, a, sel, fl, rR);
    #1;
    chk({nm, " fetchR"}, DW'(bus.fetchR), DW'(eFR));
    chk({nm, " memReqV"}, DW'(bus.memReqV), DW'(eReq));
    chk({nm, " memAddr"}, DW'(bus.memAddr), DW'(a));
    chk({nm, " rspV"}, DW'(bus.rspV), DW'(eRspV));
    if (eRspV) begin
      chk({nm, " rspSel"}, DW'(bus.rspSel), DW'(eSel));
      chk({nm, " rspData"}, bus.rspData, lineOf(eA));
    end
  endtask
  task automatic add(input logic fV, input addr_t a, input logic [1:0] sel, input logic fl,
                     input logic rR, input logic eFR, input logic eReq, input logic eRspV,
                     input logic [1:0] eSel, input addr_t eA);
    vecs.push_back('{fV, a, sel, fl, rR, eFR, eReq, eRspV, eSel, eA});
  endtask
  task automatic resetOutputs(input string nm, input logic eReq);
    chk({nm, " fetchR"}, DW'(bus.fetchR), DW'(1'b1));
    chk({nm, " memReqV"}, DW'(bus.memReqV), DW'(eReq));
    chk({nm, " rspV"}, DW'(bus.rspV), '0);
    chk({nm, " rspSel"}, DW'(bus.rspSel), '0);
    chk({nm, " rspData"}, bus.rspData, '0);
  endtask
  initial begin
    // single fetch
    add(1, 'h10, 2, 0, 1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 1, 2, 'h10);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    // short stream
    for (int k = 0; k < 9; k++)
      add(k < 6, k < 6 ? addr_t'('h20 + k) : '0, 2'(k), 0, 1, 1, k < 6, k >= 3, 2'(k - 3), addr_t'('h20 + k - 3));
    // backpressure until credits run out, then drain
    for (int k = 0; k < 6; k++)
      add(1, addr_t'('h30 + k), 2'(k), 0, 0, k < 4, k < 4, k >= 3, 0, 'h30);
    for (int k = 0; k < 4; k++)
      add(0, 0, 0, 0, 1, k != 0, 0, 1, 2'(k), addr_t'('h30 + k));
    // two queued, two in flight, then flush with a request and a pop
    for (int k = 0; k < 4; k++)
      add(1, addr_t'('h50 + k), 2'(k), 0, 0, 1, 1, k == 3, 0, 'h50);
    add(1, 'h54, 3, 1, 1, 0, 0, 1, 0, 'h50);
    add(1, 'h40, 1, 0, 1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 1, 1, 'h40);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    drive(1, 'h7, 0, 0, 0);
    #1;
    resetOutputs("reset fv1", 1);
    drive(0, 0, 0, 0, 0);
    #1;
    resetOutputs("reset fv0", 0);
    @(negedge clk);
    rstN = 1;
    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].fV, vecs[i].a, vecs[i].sel, vecs[i].fl, vecs[i].rR,
           vecs[i].eFR, vecs[i].eReq, vecs[i].eRspV, vecs[i].eSel, vecs[i].eA);
    for (int c = 0; c < 20; c++)
      step($sformatf("stream%0d", c), c < 16, c < 16 ? addr_t'(c) : '0, 2'(c), 0, 1, 1, c < 16,
           c >= 3 && c < 19, 2'(c - 3), addr_t'(c - 3));
    for (int k = 0; k < 6; k++)
      step($sformatf("fill%0d", k), k < 4, addr_t'('h60 + k), 2'(k), 0, 0, k < 4, k < 4, k >= 3, 0, 'h60);
    #1 rstN = 0;
    #1 resetOutputs("async reset", 0);
    #1 rstN = 1;
    for (int k = 0; k < 5; k++)
      step($sformatf("post reset%0d", k), 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step("refetch0", 1, 'h70, 3, 0, 1, 1, 1, 0, 0, 0);
    step("refetch1", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step("refetch2", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step("refetch3", 0, 0, 0, 0, 1, 1, 0, 1, 3, 'h70);
    step("refetch4", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
